stream_router: RTL and testbench
================================

// Module: stream_router
// PURPOSE
// - Packet-aware 1-to-N stream router with valid/ready handshake and per-channel output FIFOs.
// - Generalises the unbuffered valid-only demux: adds backpressure, an i_last-delimited packet lock and buffering.
// - Sits between the frame source and the N_CHS parallel decoder lanes.
// - Output select is taken once per packet; a packet never splits across channels.
// PARAMETERS
// - DATA_WIDTH  32  payload width, bits.
// - N_CHS       8   output channel count, >=2.
// - FIFO_DEPTH  4   entries per channel FIFO; power of two, >=2.
// - SEL_W       log2(N_CHS) (derived, localparam)  select width.
// PORTS
// - i_clk      in   1                 clock, all logic rising-edge.
// - i_rst_n    in   1                 reset, synchronous, active-low.
// - i_data     in   DATA_WIDTH        input payload.
// - i_last     in   1                 last beat of packet.
// - i_valid    in   1                 input beat valid.
// - o_ready    out  1                 input beat accepted when i_valid&o_ready.
// - i_dev_sel  in   SEL_W             target channel, sampled on first beat of packet only.
// - o_data     out  DATA_WIDTH*N_CHS  channel k in [DATA_WIDTH*(k+1)-1 -: DATA_WIDTH].
// - o_last     out  N_CHS             per-channel last flag.
// - o_valid    out  N_CHS             per-channel valid.
// - i_ready    in   N_CHS             per-channel consumer ready.
// - o_busy     out  1                 packet in flight (FSM not IDLE).
// BEHAVIOUR
// - Reset (i_rst_n=0 at edge): FSM->IDLE, all FIFOs emptied, o_valid=0, o_last=0, o_data=0, o_busy=0.
//   o_ready=0 during the reset cycle. Reset mid-packet discards all buffered and in-flight beats.
// - FSM states: IDLE, PKT (plus DROP, see CONFIGURATION).
//   - IDLE: first accepted beat latches ch=i_dev_sel.
//     - Beat with i_last=1 -> stay IDLE (1-beat packet).
//     - Beat with i_last=0 -> PKT.
//   - PKT: i_dev_sel ignored; beats go to latched ch; accepted beat with i_last=1 -> IDLE.
// - o_ready = ~full[target]; target = i_dev_sel in IDLE, latched ch in PKT. No combinational dependence on i_ready.
// - Full FIFO: o_ready=0 even if the same channel pops that cycle.
//   - One bubble on full is accepted and required (no pop-to-push bypass).
// - Latency: beat accepted at edge t -> visible on o_valid[ch]/o_data/o_last from t+1 if FIFO was empty.
//   - No same-cycle pass-through.
// - Channel FIFO:
//   - Stores {last,data}.
//   - Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
//   - full when wr-rd==FIFO_DEPTH; empty when equal.
//   - Simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.
//   - o_valid[k]=~empty[k]; pop on o_valid[k]&i_ready[k].
// - Channels are independent: a stalled channel never blocks a packet headed to another channel once the current packet ends.
// - Order within a channel is preserved; no beat is duplicated or lost except by reset or DROP.
// CONFIGURATION
// - Macro STREAM_ROUTER_DROP_EN.
// - Defined:
//   - A packet whose first-beat i_dev_sel>=N_CHS enters DROP; o_ready=1 and beats are discarded until the i_last beat, then IDLE.
//   - Adds port o_drop_cnt (out, 16): packets dropped, saturates at 16'hFFFF, reset to 0.
//   - A 1-beat dropped packet counts and stays IDLE.
// - Undefined:
//   - No DROP state and no o_drop_cnt.
//   - An out-of-range select holds o_ready=0 in IDLE until i_dev_sel is in range.
//   - A non-power-of-two N_CHS is a legal config.
// STRUCTURE
// - math_pkg: log2() used for SEL_W.
// - stream_router_pkg: typedef enum logic[1:0] {ST_IDLE,ST_PKT,ST_DROP} router_state_t; DROP_CNT_W=16.
// - Sub-module stream_router_fifo (DATA_WIDTH+1, FIFO_DEPTH, sync active-low reset), instantiated N_CHS times in a generate loop.
// TESTING
// - Reset: hold i_rst_n=0 3 cycles with i_valid=1 -> o_valid=0, o_ready=0, o_busy=0.
//   - Release -> o_ready=1 on the next cycle.
// - Routing: pkt A {0x11,0x12,0x13(last)} sel=2, then pkt B {0x21(last)} sel=5, all i_ready=1.
//   - Ch2 emits 0x11..0x13 at t+1..t+3 with o_last on 0x13; ch5 emits 0x21 with o_last.
// - Packet lock: change i_dev_sel 2->6 on beat 2 of a 4-beat packet -> all 4 beats on ch2, none on ch6.
// - Backpressure: FIFO_DEPTH=4, i_ready[3]=0, send 6 beats sel=3.
//   - o_ready drops after the 4th accept.
//   - Raise i_ready[3] -> remaining 2 accepted in order, one bubble.
//   - Output 0..5 in order.
// - Independence: ch1 full and stalled; new packet sel=4 after ch1 packet ends -> accepted at full rate on ch4.
// - DROP (macro on): sel=N_CHS 3-beat packet -> o_ready=1 for 3 cycles, no o_valid, o_drop_cnt=1.
//   - Reset mid-packet -> next packet's first beat latches a fresh select.

Source files
------------

// File: rtl/math_pkg.sv
// Small math helpers shared by the stream router files.
package math_pkg;

  // Ceiling log2 of v; returns 0 for v <= 1.
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_router_pkg.sv
// Shared types and constants for the stream router.
// The DROP state is only reachable when STREAM_ROUTER_DROP_EN is defined.
package stream_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } router_state_t;

  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/stream_router_fifo.sv
// Per-channel FIFO holding {last,data} entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Read data is forced to zero while empty so idle channels present o_data=0.
module stream_router_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign o_full  = (count == PW'(DEPTH));
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;
  assign o_rdata = o_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer and storage values for push and pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = i_wdata;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer and storage registers; reset empties the FIFO.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/stream_router.sv
// Packet-aware 1-to-N stream router with per-channel output FIFOs.
// The channel is chosen on the first beat of a packet and held until i_last.
// Optional feature macro: STREAM_ROUTER_DROP_EN (discard packets whose
// select is out of range and count them on o_drop_cnt).
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; valid must not depend on ready, and o_ready never depends on i_ready.
module stream_router
  import math_pkg::*;
  import stream_router_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int N_CHS      = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int SEL_W      = log2(N_CHS)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic                        i_last,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [SEL_W-1:0]            i_dev_sel,
  output logic [DATA_WIDTH*N_CHS-1:0] o_data,
  output logic [N_CHS-1:0]            o_last,
  output logic [N_CHS-1:0]            o_valid,
  input  logic [N_CHS-1:0]            i_ready,
`ifdef STREAM_ROUTER_DROP_EN
  output logic [DROP_CNT_W-1:0]       o_drop_cnt,
`endif
  output router_state_t               o_dbg_state,
  output logic                        o_busy
);

  router_state_t    state_q, state_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [SEL_W-1:0] target;
  logic             tgt_ok;
  logic             rdy;
  logic             accept;
  logic             push_en;
  logic [SEL_W-1:0] push_ch;
  logic [N_CHS-1:0] full;
  logic [N_CHS-1:0] empty;

`ifdef STREAM_ROUTER_DROP_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  assign o_drop_cnt = drop_cnt_q;
`endif

  assign o_busy      = (state_q != ST_IDLE);
  assign o_dbg_state = state_q;
  assign o_ready     = i_rst_n & rdy;
  assign accept      = i_valid & o_ready;

  // Target selection, input readiness and packet-lock next state.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    push_en = 1'b0;
    push_ch = ch_q;
    rdy     = 1'b0;
`ifdef STREAM_ROUTER_DROP_EN
    drop_cnt_d = drop_cnt_q;
`endif
    target = (state_q == ST_PKT) ? ch_q : i_dev_sel;
    tgt_ok = ({1'b0, target} < (SEL_W + 1)'(N_CHS));

    case (state_q)
      ST_IDLE: begin
        if (tgt_ok) begin
          rdy = ~full[target];
        end else begin
`ifdef STREAM_ROUTER_DROP_EN
          rdy = 1'b1;
`else
          rdy = 1'b0;
`endif
        end
        if (i_valid && i_rst_n && rdy) begin
          if (tgt_ok) begin
            ch_d    = i_dev_sel;
            push_en = 1'b1;
            push_ch = i_dev_sel;
            if (!i_last) state_d = ST_PKT;
          end else begin
`ifdef STREAM_ROUTER_DROP_EN
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
            if (!i_last) state_d = ST_DROP;
`endif
          end
        end
      end
      ST_PKT: begin
        rdy = ~full[ch_q];
        if (i_valid && i_rst_n && rdy) begin
          push_en = 1'b1;
          push_ch = ch_q;
          if (i_last) state_d = ST_IDLE;
        end
      end
`ifdef STREAM_ROUTER_DROP_EN
      ST_DROP: begin
        rdy = 1'b1;
        if (i_valid && i_rst_n && i_last) state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and latched channel registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

`ifdef STREAM_ROUTER_DROP_EN
  // Dropped-packet counter, saturating.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end
`endif

  for (genvar k = 0; k < N_CHS; k++) begin : g_ch
    logic [DATA_WIDTH:0] rdata;
    logic                push;

    assign push = push_en & (push_ch == SEL_W'(k));

    stream_router_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push),
      .i_wdata ({i_last, i_data}),
      .i_pop   (i_ready[k]),
      .o_rdata (rdata),
      .o_full  (full[k]),
      .o_empty (empty[k])
    );

    assign o_valid[k]                             = ~empty[k];
    assign o_last[k]                              = rdata[DATA_WIDTH];
    assign o_data[DATA_WIDTH*(k+1)-1 -: DATA_WIDTH] = rdata[DATA_WIDTH-1:0];
  end

  // accept is kept for readability of the handshake; it mirrors the push path.
  logic unused_accept;
  assign unused_accept = accept;

endmodule

// File: tb/tb_stream_router.sv
// Directed testbench for stream_router (default build, N_CHS=8, FIFO_DEPTH=4).
module tb_stream_router;
  import stream_router_pkg::*;

  localparam int DW = 32;
  localparam int NC = 8;
  localparam int FD = 4;
  localparam int SW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              i_rst_n;
  logic [DW-1:0]     i_data;
  logic              i_last;
  logic              i_valid;
  logic              o_ready;
  logic [SW-1:0]     i_dev_sel;
  logic [DW*NC-1:0]  o_data;
  logic [NC-1:0]     o_last;
  logic [NC-1:0]     o_valid;
  logic [NC-1:0]     i_ready;
  router_state_t     o_dbg_state;
  logic              o_busy;
`ifdef STREAM_ROUTER_DROP_EN
  logic [15:0]       o_drop_cnt;
`endif

  stream_router #(.DATA_WIDTH(DW), .N_CHS(NC), .FIFO_DEPTH(FD)) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_data      (i_data),
    .i_last      (i_last),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_dev_sel   (i_dev_sel),
    .o_data      (o_data),
    .o_last      (o_last),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
`ifdef STREAM_ROUTER_DROP_EN
    .o_drop_cnt  (o_drop_cnt),
`endif
    .o_dbg_state (o_dbg_state),
    .o_busy      (o_busy)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- scoreboard ----------------
  logic [DW:0] got_q [NC][$];
  logic [DW:0] exp_q [$];

  // Record every beat leaving each channel ({last,data}).
  always @(negedge clk) begin
    for (int k = 0; k < NC; k++) begin
      if (o_valid[k] === 1'b1 && i_ready[k] === 1'b1)
        got_q[k].push_back({o_last[k], o_data[DW*k +: DW]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) next_cyc();
  endtask

  task automatic clear_q();
    for (int k = 0; k < NC; k++) got_q[k].delete();
    exp_q.delete();
  endtask

  task automatic idle_in();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [SW-1:0] sel, input logic [DW-1:0] d,
                           input logic last);
    bit ok;
    ok        = 1'b0;
    i_valid   = 1'b1;
    i_data    = d;
    i_last    = last;
    i_dev_sel = sel;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (o_ready === 1'b1) ok = 1'b1;
      next_cyc();
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout data=%h got o_ready=0 required 1", d);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst_n   = 1'b0;
    i_valid   = 1'b1;
    i_last    = 1'b0;
    i_dev_sel = 3'd2;
    i_data    = 32'hdead_beef;
    i_ready   = '1;
    for (int c = 0; c < 3; c++) begin
      next_cyc();
      tests_run++;
      if (o_valid !== '0) begin
        tests_failed++;
        $display("FAIL reset_o_valid cyc=%0d got %b required 0", c, o_valid);
      end
      tests_run++;
      if (o_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_o_ready cyc=%0d got %b required 0", c, o_ready);
      end
      tests_run++;
      if (o_busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_o_busy cyc=%0d got %b required 0", c, o_busy);
      end
    end
    idle_in();
    i_rst_n = 1'b1;
    next_cyc();
    tests_run++;
    if (o_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready got %b required 1", o_ready);
    end
    tests_run++;
    if (o_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_o_data got %h required 0", o_data);
    end
  endtask

  task automatic test_routing();
    clear_q();
    i_ready = '1;
    send_beat(3'd2, 32'h11, 1'b0);
    // Beat accepted at the previous edge is now at the head of channel 2.
    tests_run++;
    if (o_valid[2] !== 1'b1 || o_data[95:64] !== 32'h11 || o_last[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL route_latency got v=%b d=%h l=%b required v=1 d=11 l=0",
               o_valid[2], o_data[95:64], o_last[2]);
    end
    send_beat(3'd2, 32'h12, 1'b0);
    send_beat(3'd2, 32'h13, 1'b1);
    send_beat(3'd5, 32'h21, 1'b1);
    idle_in();
    wait_cycles(5);
    exp_q = '{{1'b0, 32'h11}, {1'b0, 32'h12}, {1'b1, 32'h13}};
    tests_run++;
    if (got_q[2].size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL route_ch2_count got %0d required %0d", got_q[2].size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q[2].size(); i++) begin
      tests_run++;
      if (got_q[2][i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL route_ch2_beat%0d got %h required %h", i, got_q[2][i], exp_q[i]);
      end
    end
    tests_run++;
    if (got_q[5].size() != 1 || got_q[5][0] !== {1'b1, 32'h21}) begin
      tests_failed++;
      $display("FAIL route_ch5 got size %0d required single beat 1_00000021", got_q[5].size());
    end
    tests_run++;
    if (got_q[0].size() + got_q[1].size() + got_q[3].size() + got_q[4].size()
        + got_q[6].size() + got_q[7].size() != 0) begin
      tests_failed++;
      $display("FAIL route_stray got beats on unselected channels required none");
    end
  endtask

  task automatic test_lock();
    clear_q();
    i_ready = '1;
    send_beat(3'd2, 32'h31, 1'b0);
    tests_run++;
    if (o_busy !== 1'b1 || o_dbg_state !== ST_PKT) begin
      tests_failed++;
      $display("FAIL lock_busy got busy=%b state=%0d required busy=1 state=1", o_busy, o_dbg_state);
    end
    send_beat(3'd6, 32'h32, 1'b0);
    send_beat(3'd6, 32'h33, 1'b0);
    send_beat(3'd6, 32'h34, 1'b1);
    idle_in();
    tests_run++;
    if (o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_end_busy got %b required 0", o_busy);
    end
    wait_cycles(5);
    exp_q = '{{1'b0, 32'h31}, {1'b0, 32'h32}, {1'b0, 32'h33}, {1'b1, 32'h34}};
    tests_run++;
    if (got_q[2].size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL lock_ch2_count got %0d required %0d", got_q[2].size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q[2].size(); i++) begin
      tests_run++;
      if (got_q[2][i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL lock_ch2_beat%0d got %h required %h", i, got_q[2][i], exp_q[i]);
      end
    end
    tests_run++;
    if (got_q[6].size() != 0) begin
      tests_failed++;
      $display("FAIL lock_ch6_count got %0d required 0", got_q[6].size());
    end
  endtask

  task automatic test_backpressure();
    clear_q();
    i_ready    = '1;
    i_ready[3] = 1'b0;
    for (int b = 0; b < 4; b++) send_beat(3'd3, DW'(b), 1'b0);
    // FIFO for channel 3 now holds 4 beats: beat 4 must stall.
    i_valid = 1'b1; i_data = 32'd4; i_last = 1'b0; i_dev_sel = 3'd3;
    @(negedge clk);
    tests_run++;
    if (o_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_full_ready got %b required 0", o_ready);
    end
    next_cyc();
    @(negedge clk);
    tests_run++;
    if (o_ready !== 1'b0 || o_valid[3] !== 1'b1 || o_data[127:96] !== 32'd0) begin
      tests_failed++;
      $display("FAIL bp_hold got rdy=%b v=%b d=%h required rdy=0 v=1 d=0",
               o_ready, o_valid[3], o_data[127:96]);
    end
    next_cyc();
    i_ready[3] = 1'b1;
    @(negedge clk);
    tests_run++;
    if (o_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_bubble got %b required 0", o_ready);
    end
    next_cyc();
    @(negedge clk);
    tests_run++;
    if (o_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_resume got %b required 1", o_ready);
    end
    next_cyc();
    send_beat(3'd3, 32'd5, 1'b1);
    idle_in();
    wait_cycles(8);
    for (int b = 0; b < 6; b++) exp_q.push_back({(b == 5) ? 1'b1 : 1'b0, DW'(b)});
    tests_run++;
    if (got_q[3].size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL bp_ch3_count got %0d required %0d", got_q[3].size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q[3].size(); i++) begin
      tests_run++;
      if (got_q[3][i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL bp_ch3_beat%0d got %h required %h", i, got_q[3][i], exp_q[i]);
      end
    end
  endtask

  task automatic test_independence();
    clear_q();
    i_ready    = '1;
    i_ready[1] = 1'b0;
    send_beat(3'd1, 32'h41, 1'b0);
    send_beat(3'd1, 32'h42, 1'b0);
    send_beat(3'd1, 32'h43, 1'b0);
    send_beat(3'd1, 32'h44, 1'b1);
    for (int b = 0; b < 3; b++) begin
      i_valid = 1'b1; i_data = 32'h51 + DW'(b); i_last = (b == 2); i_dev_sel = 3'd4;
      @(negedge clk);
      tests_run++;
      if (o_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL indep_rate beat%0d got %b required 1", b, o_ready);
      end
      next_cyc();
    end
    idle_in();
    wait_cycles(4);
    exp_q = '{{1'b0, 32'h51}, {1'b0, 32'h52}, {1'b1, 32'h53}};
    tests_run++;
    if (got_q[4].size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL indep_ch4_count got %0d required %0d", got_q[4].size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q[4].size(); i++) begin
      tests_run++;
      if (got_q[4][i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL indep_ch4_beat%0d got %h required %h", i, got_q[4][i], exp_q[i]);
      end
    end
    tests_run++;
    if (got_q[1].size() != 0) begin
      tests_failed++;
      $display("FAIL indep_ch1_stalled got %0d required 0", got_q[1].size());
    end
    i_ready[1] = 1'b1;
    wait_cycles(6);
    exp_q = '{{1'b0, 32'h41}, {1'b0, 32'h42}, {1'b0, 32'h43}, {1'b1, 32'h44}};
    tests_run++;
    if (got_q[1].size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL indep_ch1_count got %0d required %0d", got_q[1].size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q[1].size(); i++) begin
      tests_run++;
      if (got_q[1][i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL indep_ch1_beat%0d got %h required %h", i, got_q[1][i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] sels [3];
    clear_q();
    i_ready = '1;
    sels = '{3'd0, 3'd7, 3'd3};
    for (int b = 0; b < 3; b++) begin
      i_valid = 1'b1; i_data = 32'h61 + DW'(b); i_last = 1'b1; i_dev_sel = sels[b];
      @(negedge clk);
      tests_run++;
      if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_beat%0d got rdy=%b busy=%b required rdy=1 busy=0", b, o_ready, o_busy);
      end
      next_cyc();
    end
    idle_in();
    wait_cycles(4);
    tests_run++;
    if (got_q[0].size() != 1 || got_q[0][0] !== {1'b1, 32'h61}) begin
      tests_failed++;
      $display("FAIL b2b_ch0 got size %0d required one beat 1_00000061", got_q[0].size());
    end
    tests_run++;
    if (got_q[7].size() != 1 || got_q[7][0] !== {1'b1, 32'h62}) begin
      tests_failed++;
      $display("FAIL b2b_ch7 got size %0d required one beat 1_00000062", got_q[7].size());
    end
    tests_run++;
    if (got_q[3].size() != 1 || got_q[3][0] !== {1'b1, 32'h63}) begin
      tests_failed++;
      $display("FAIL b2b_ch3 got size %0d required one beat 1_00000063", got_q[3].size());
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    i_ready    = '1;
    i_ready[2] = 1'b0;
    send_beat(3'd2, 32'h71, 1'b0);
    send_beat(3'd2, 32'h72, 1'b0);
    tests_run++;
    if (o_busy !== 1'b1 || o_valid[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_pre got busy=%b v2=%b required 1 1", o_busy, o_valid[2]);
    end
    i_rst_n = 1'b0;
    i_valid = 1'b1; i_data = 32'h73; i_dev_sel = 3'd2;
    next_cyc();
    tests_run++;
    if (o_valid !== '0 || o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_flush got v=%b busy=%b required v=0 busy=0", o_valid, o_busy);
    end
    idle_in();
    i_rst_n = 1'b1;
    next_cyc();
    send_beat(3'd6, 32'h81, 1'b1);
    idle_in();
    i_ready[2] = 1'b1;
    wait_cycles(4);
    tests_run++;
    if (got_q[6].size() != 1 || got_q[6][0] !== {1'b1, 32'h81}) begin
      tests_failed++;
      $display("FAIL rstmid_ch6 got size %0d required one beat 1_00000081", got_q[6].size());
    end
    tests_run++;
    if (got_q[2].size() != 0) begin
      tests_failed++;
      $display("FAIL rstmid_ch2 got %0d beats required 0", got_q[2].size());
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    i_rst_n   = 1'b0;
    i_data    = '0;
    i_last    = 1'b0;
    i_valid   = 1'b0;
    i_dev_sel = '0;
    i_ready   = '1;
    test_reset();
    test_routing();
    test_lock();
    test_backpressure();
    test_independence();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
